// File: rtl/memory_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package : memory_access_stage_pkg
// Purpose : Encodings shared by the decoder, execution stage and memory
//           access stage: load/store operation codes, the memory-stage FSM
//           state encoding and the byte-strobe constants.
// Revision: 1.0  initial release
// ============================================================================
package memory_access_stage_pkg;

   typedef enum logic [2:0] {
      LOAD_NONE = 3'd0,
      LOAD_B    = 3'd1,
      LOAD_H    = 3'd2,
      LOAD_W    = 3'd3,
      LOAD_BU   = 3'd4,
      LOAD_HU   = 3'd5
   } load_e;

   typedef enum logic [1:0] {
      STORE_NONE = 2'd0,
      STORE_B    = 2'd1,
      STORE_H    = 2'd2,
      STORE_W    = 2'd3
   } store_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_RESP = 2'd2
   } state_e;

   localparam logic [3:0] WSTRB_NONE = 4'b0000;
   localparam logic [3:0] WSTRB_B0   = 4'b0001;
   localparam logic [3:0] WSTRB_H_LO = 4'b0011;
   localparam logic [3:0] WSTRB_H_HI = 4'b1100;
   localparam logic [3:0] WSTRB_W    = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/memory_access_stage_load_store_aligner.sv
`default_nettype none
// ============================================================================
// Module  : load_store_aligner
// Purpose : Combinational byte-lane logic for the memory access stage.
//           Store side: byte strobes, lane-replicated write data and the
//           misaligned flag for the incoming operation.
//           Load side : byte/half selection and sign/zero extension of the
//           returned cache word for the registered operation.
// Ports   : st_off_i      low address bits of the incoming op
//           store_i       incoming store type
//           load_i        incoming load type (already NONE when a store wins)
//           st_data_i     raw store data
//           wstrb_o       byte strobes (0 for non-stores)
//           wdata_o       store data replicated into every candidate lane
//           misaligned_o  incoming op violates its natural alignment
//           ld_type_i     registered load type
//           ld_off_i      registered low address bits
//           rdata_i       word returned by the cache
//           ld_data_o     extracted and extended load value
// Revision: 1.0  initial release
// ============================================================================
module load_store_aligner
   import memory_access_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        st_off_i,
   input  store_e            store_i,
   input  load_e             load_i,
   input  logic [DATA_W-1:0] st_data_i,
   output logic [3:0]        wstrb_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              misaligned_o,
   input  load_e             ld_type_i,
   input  logic [1:0]        ld_off_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [DATA_W-1:0] ld_data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      wstrb_o      = WSTRB_NONE;
      wdata_o      = '0;
      misaligned_o = 1'b0;
      case (store_i)
         STORE_B: begin
            wstrb_o = WSTRB_B0 << st_off_i;
            wdata_o = {4{st_data_i[7:0]}};
         end
         STORE_H: begin
            wstrb_o      = st_off_i[1] ? WSTRB_H_HI : WSTRB_H_LO;
            wdata_o      = {2{st_data_i[15:0]}};
            misaligned_o = st_off_i[0];
         end
         STORE_W: begin
            wstrb_o      = WSTRB_W;
            wdata_o      = st_data_i;
            misaligned_o = (st_off_i != 2'b00);
         end
         default: begin
            case (load_i)
               LOAD_H, LOAD_HU: misaligned_o = st_off_i[0];
               LOAD_W:          misaligned_o = (st_off_i != 2'b00);
               default:         misaligned_o = 1'b0;
            endcase
         end
      endcase
   end

   always_comb begin
      case (ld_off_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (ld_type_i)
         LOAD_B:  ld_data_o = {{24{byte_sel[7]}}, byte_sel};
         LOAD_H:  ld_data_o = {{16{half_sel[15]}}, half_sel};
         LOAD_BU: ld_data_o = {24'd0, byte_sel};
         LOAD_HU: ld_data_o = {16'd0, half_sel};
         default: ld_data_o = rdata_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : memory_access_stage
// Purpose : Pipeline stage after execute. Registers the execute outputs,
//           issues loads/stores over a valid/ready data-cache port, aligns
//           and extends load data and drives the registered write-back bundle.
//           Stalls upstream while a cache transaction is outstanding.
// Ports   : CLK, RST (async, active-high)
//           STALL_MEMORY_STAGE / CLEAR_MEMORY_STAGE  hold / bubble controls
//           RD_ADDRESS_IN .. RD_WRITE_ENABLE_IN      execute-stage bundle
//           DC_REQ_*  / DC_RESP_*                    data-cache port
//           RD_ADDRESS_OUT, WRITE_BACK_DATA_OUT,
//           RD_WRITE_ENABLE_OUT                      write-back bundle
//           MISALIGNED_OUT                           misaligned-access pulse
//           STALL_PIPELINE_OUT                       freeze upstream stages
// Revision: 1.0  initial release
// ============================================================================
module memory_access_stage
   import memory_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              STALL_MEMORY_STAGE,
   input  logic              CLEAR_MEMORY_STAGE,
   input  logic [4:0]        RD_ADDRESS_IN,
   input  logic [DATA_W-1:0] ALU_OUT_IN,
   input  logic [2:0]        DATA_CACHE_READ_IN,
   input  logic [1:0]        DATA_CACHE_WRITE_IN,
   input  logic [DATA_W-1:0] DATA_CACHE_WRITE_DATA_IN,
   input  logic              WRITE_BACK_MUX_SELECT_IN,
   input  logic              RD_WRITE_ENABLE_IN,
   output logic              DC_REQ_VALID,
   input  logic              DC_REQ_READY,
   output logic [ADDR_W-1:0] DC_REQ_ADDR,
   output logic [3:0]        DC_REQ_WSTRB,
   output logic [DATA_W-1:0] DC_REQ_WDATA,
   input  logic              DC_RESP_VALID,
   input  logic [DATA_W-1:0] DC_RESP_DATA,
   output logic [4:0]        RD_ADDRESS_OUT,
   output logic [DATA_W-1:0] WRITE_BACK_DATA_OUT,
   output logic              RD_WRITE_ENABLE_OUT,
   output logic              MISALIGNED_OUT,
   output logic              STALL_PIPELINE_OUT
);

   state_e              state_q, state_d;
   logic [4:0]          rd_q, rd_d;
   logic [DATA_W-1:0]   alu_q, alu_d;
   load_e               ld_q, ld_d;
   logic                store_q, store_d;
   logic                wbsel_q, wbsel_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   dc_addr_q, dc_addr_d;
   logic [3:0]          dc_wstrb_q, dc_wstrb_d;
   logic [DATA_W-1:0]   dc_wdata_q, dc_wdata_d;
   logic [4:0]          rd_out_q, rd_out_d;
   logic [DATA_W-1:0]   wb_q, wb_d;
   logic                wen_q, wen_d;
   logic                mis_q, mis_d;

   store_e              st_in;
   load_e               ld_in;
   logic [3:0]          al_wstrb;
   logic [DATA_W-1:0]   al_wdata;
   logic                al_mis;
   logic [DATA_W-1:0]   ld_data;
   logic                completing;

   // A store wins over a simultaneous load; unused read codes act as no load.
   always_comb begin
      st_in = store_e'(DATA_CACHE_WRITE_IN);
      if (st_in != STORE_NONE || DATA_CACHE_READ_IN > 3'd5) begin
         ld_in = LOAD_NONE;
      end else begin
         ld_in = load_e'(DATA_CACHE_READ_IN);
      end
   end

   load_store_aligner #(.DATA_W(DATA_W)) u_aligner (
      .st_off_i     (ALU_OUT_IN[1:0]),
      .store_i      (st_in),
      .load_i       (ld_in),
      .st_data_i    (DATA_CACHE_WRITE_DATA_IN),
      .wstrb_o      (al_wstrb),
      .wdata_o      (al_wdata),
      .misaligned_o (al_mis),
      .ld_type_i    (ld_q),
      .ld_off_i     (alu_q[1:0]),
      .rdata_i      (DC_RESP_DATA),
      .ld_data_o    (ld_data)
   );

   always_comb begin
      state_d    = state_q;
      rd_d       = rd_q;
      alu_d      = alu_q;
      ld_d       = ld_q;
      store_d    = store_q;
      wbsel_d    = wbsel_q;
      we_d       = we_q;
      dc_addr_d  = dc_addr_q;
      dc_wstrb_d = dc_wstrb_q;
      dc_wdata_d = dc_wdata_q;
      rd_out_d   = rd_out_q;
      wb_d       = wb_q;
      wen_d      = 1'b0;
      mis_d      = 1'b0;
      completing = 1'b0;
      case (state_q)
         IDLE: begin
            if (!STALL_MEMORY_STAGE) begin
               if (CLEAR_MEMORY_STAGE) begin
                  ld_d    = LOAD_NONE;
                  store_d = 1'b0;
                  we_d    = 1'b0;
               end else begin
                  rd_d    = RD_ADDRESS_IN;
                  alu_d   = ALU_OUT_IN;
                  ld_d    = ld_in;
                  store_d = (st_in != STORE_NONE);
                  wbsel_d = WRITE_BACK_MUX_SELECT_IN;
                  we_d    = RD_WRITE_ENABLE_IN;
                  if (al_mis) begin
                     mis_d = 1'b1;
                  end else if (st_in != STORE_NONE || ld_in != LOAD_NONE) begin
                     state_d    = REQ;
                     dc_addr_d  = {ALU_OUT_IN[ADDR_W-1:2], 2'b00};
                     dc_wstrb_d = al_wstrb;
                     dc_wdata_d = al_wdata;
                  end else begin
                     rd_out_d = RD_ADDRESS_IN;
                     wb_d     = ALU_OUT_IN;
                     wen_d    = RD_WRITE_ENABLE_IN;
                  end
               end
            end
         end
         REQ: begin
            if (DC_REQ_READY) begin
               if (store_q) begin
                  state_d    = IDLE;
                  completing = 1'b1;
               end else begin
                  state_d = WAIT_RESP;
               end
            end
         end
         WAIT_RESP: begin
            if (DC_RESP_VALID) begin
               state_d    = IDLE;
               completing = 1'b1;
               rd_out_d   = rd_q;
               wb_d       = wbsel_q ? ld_data : alu_q;
               wen_d      = we_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         rd_q       <= '0;
         alu_q      <= '0;
         ld_q       <= LOAD_NONE;
         store_q    <= 1'b0;
         wbsel_q    <= 1'b0;
         we_q       <= 1'b0;
         dc_addr_q  <= '0;
         dc_wstrb_q <= '0;
         dc_wdata_q <= '0;
         rd_out_q   <= '0;
         wb_q       <= '0;
         wen_q      <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_q       <= rd_d;
         alu_q      <= alu_d;
         ld_q       <= ld_d;
         store_q    <= store_d;
         wbsel_q    <= wbsel_d;
         we_q       <= we_d;
         dc_addr_q  <= dc_addr_d;
         dc_wstrb_q <= dc_wstrb_d;
         dc_wdata_q <= dc_wdata_d;
         rd_out_q   <= rd_out_d;
         wb_q       <= wb_d;
         wen_q      <= wen_d;
         mis_q      <= mis_d;
      end
   end

   // Valid is decoded straight from the state register so reset drops it
   // without waiting for a clock edge.
   assign DC_REQ_VALID        = (state_q == REQ);
   assign DC_REQ_ADDR         = dc_addr_q;
   assign DC_REQ_WSTRB        = dc_wstrb_q;
   assign DC_REQ_WDATA        = dc_wdata_q;
   assign RD_ADDRESS_OUT      = rd_out_q;
   assign WRITE_BACK_DATA_OUT = wb_q;
   assign RD_WRITE_ENABLE_OUT = wen_q;
   assign MISALIGNED_OUT      = mis_q;
   // Released in the completing cycle so upstream advances on the same edge.
   assign STALL_PIPELINE_OUT  = (state_q != IDLE) && !completing;

endmodule
`default_nettype wire
